// File: rtl/program_loader_pkg.sv
// Shared definitions for the program loader.
//   loader_state_t     : load sequencing states
//   BYTES_PER_WORD     : bytes assembled into each program word (high byte first)
//   LENGTH_FIELD_BYTES : bytes in the leading word-count field (high byte first)
//   accepts_byte()     : states in which the loader consumes stream bytes
package program_loader_pkg;

    typedef enum logic [2:0] {
        IDLE,
        LEN_HI,
        LEN_LO,
        DATA_HI,
        DATA_LO,
        WRITE,
        DONE,
        ERROR
    } loader_state_t;

    localparam int BYTES_PER_WORD     = 2;
    localparam int LENGTH_FIELD_BYTES = 2;

    function automatic logic accepts_byte(input loader_state_t s);
        return (s == LEN_HI) || (s == LEN_LO) || (s == DATA_HI) || (s == DATA_LO);
    endfunction

endpackage

// File: rtl/program_loader.sv
// Program RAM writer. Takes a byte stream (length field, then program words,
// all high byte first) over a valid/ready handshake, writes each word into
// program RAM through the memory controller write path, and enables execution
// only once a complete, in-range image has been written.
//
// Ports:
//   clock, reset_n     : rising-edge clock, asynchronous active-low reset
//   start              : one-cycle pulse; begins a load from IDLE/DONE/ERROR
//   rx_data, rx_valid  : incoming byte and its valid flag
//   rx_ready           : loader takes a byte this cycle (registered)
//   mem_address        : write address to the memory controller
//   mem_data           : write data to the memory controller
//   mem_write          : write strobe, high for the single WRITE cycle
//   busy               : load in progress
//   done               : image loaded successfully
//   error              : length field exceeded MEMORY_DEPTH
//   execution_enable   : execution driver enable, follows done
//   words_written      : words written in the current/last load
module program_loader
    import program_loader_pkg::*;
#(
    parameter int ADDRESS_WIDTH = 16,
    parameter int DATA_WIDTH    = 16,
    parameter int MEMORY_DEPTH  = 64,
    parameter int BASE_ADDRESS  = 0
) (
    input  logic                     clock,
    input  logic                     reset_n,
    input  logic                     start,
    input  logic [7:0]               rx_data,
    input  logic                     rx_valid,
    output logic                     rx_ready,
    output logic [ADDRESS_WIDTH-1:0] mem_address,
    output logic [DATA_WIDTH-1:0]    mem_data,
    output logic                     mem_write,
    output logic                     busy,
    output logic                     done,
    output logic                     error,
    output logic                     execution_enable,
    output logic [ADDRESS_WIDTH-1:0] words_written
);

    localparam int                      LENGTH_WIDTH = 8 * LENGTH_FIELD_BYTES;
    localparam logic [LENGTH_WIDTH-1:0] MAX_LENGTH   = LENGTH_WIDTH'(MEMORY_DEPTH);

    loader_state_t            state;
    loader_state_t            next_state;
    logic [7:0]               length_hi;
    logic [7:0]               word_hi;
    logic [LENGTH_WIDTH-1:0]  remaining;
    logic [ADDRESS_WIDTH-1:0] address;
    logic [LENGTH_WIDTH-1:0]  length_field;
    logic                     transfer;
    logic                     start_load;

    // rx_ready is itself a function of state, so a transfer can only be
    // seen in the four byte-accepting states.
    assign transfer     = rx_valid && rx_ready;
    assign start_load   = start && (state == IDLE || state == DONE || state == ERROR);
    assign length_field = {length_hi, rx_data};

    // NOTE: every variable assigned in always_comb gets a default first, so
    // no path through the case leaves it unassigned and no latch is inferred.
    always_comb begin
        next_state = state;
        unique case (state)
            IDLE, DONE, ERROR: begin
                if (start_load) next_state = LEN_HI;
            end
            LEN_HI: begin
                if (transfer) next_state = LEN_LO;
            end
            LEN_LO: begin
                if (transfer) begin
                    if (length_field == '0)             next_state = DONE;
                    else if (length_field > MAX_LENGTH) next_state = ERROR;
                    else                                next_state = DATA_HI;
                end
            end
            DATA_HI: begin
                if (transfer) next_state = DATA_LO;
            end
            DATA_LO: begin
                if (transfer) next_state = WRITE;
            end
            WRITE: begin
                next_state = (remaining == LENGTH_WIDTH'(1)) ? DONE : DATA_HI;
            end
            default: next_state = IDLE;
        endcase
    end

    // Status outputs are registered from next_state so they line up exactly
    // with the state they describe and carry no decode glitches.
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state            <= IDLE;
            rx_ready         <= 1'b0;
            mem_write        <= 1'b0;
            busy             <= 1'b0;
            done             <= 1'b0;
            error            <= 1'b0;
            execution_enable <= 1'b0;
        end else begin
            state            <= next_state;
            rx_ready         <= accepts_byte(next_state);
            mem_write        <= (next_state == WRITE);
            busy             <= !(next_state == IDLE || next_state == DONE || next_state == ERROR);
            done             <= (next_state == DONE);
            error            <= (next_state == ERROR);
            execution_enable <= (next_state == DONE);
        end
    end

    // Datapath. mem_address/mem_data are loaded only as WRITE is entered, so
    // they stay stable through WRITE and hold afterwards while the internal
    // address moves on to the next word.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            length_hi     <= '0;
            word_hi       <= '0;
            remaining     <= '0;
            address       <= '0;
            mem_address   <= '0;
            mem_data      <= '0;
            words_written <= '0;
        end else begin
            if (start_load) begin
                words_written <= '0;
            end
            unique case (state)
                LEN_HI: begin
                    if (transfer) length_hi <= rx_data;
                end
                LEN_LO: begin
                    if (transfer) begin
                        address   <= ADDRESS_WIDTH'(BASE_ADDRESS);
                        remaining <= length_field;
                    end
                end
                DATA_HI: begin
                    if (transfer) word_hi <= rx_data;
                end
                DATA_LO: begin
                    if (transfer) begin
                        mem_address <= address;
                        mem_data    <= DATA_WIDTH'({word_hi, rx_data});
                    end
                end
                WRITE: begin
                    address       <= address + 1'b1;
                    remaining     <= remaining - 1'b1;
                    words_written <= words_written + 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_program_loader.sv
// Randomized scoreboard bench for program_loader. A reference model derives
// the expected RAM writes and final status from each byte stream; a monitor
// compares every observed mem_write against the queue of expected writes.
module tb_program_loader;
    import program_loader_pkg::*;

    localparam int AW    = 16;
    localparam int DW    = 16;
    localparam int DEPTH = 64;
    localparam int BASE  = 0;

    logic          clock;
    logic          reset_n;
    logic          start;
    logic [7:0]    rx_data;
    logic          rx_valid;
    logic          rx_ready;
    logic [AW-1:0] mem_address;
    logic [DW-1:0] mem_data;
    logic          mem_write;
    logic          busy;
    logic          done;
    logic          error;
    logic          execution_enable;
    logic [AW-1:0] words_written;

    program_loader #(
        .ADDRESS_WIDTH(AW),
        .DATA_WIDTH   (DW),
        .MEMORY_DEPTH (DEPTH),
        .BASE_ADDRESS (BASE)
    ) dut (
        .clock           (clock),
        .reset_n         (reset_n),
        .start           (start),
        .rx_data         (rx_data),
        .rx_valid        (rx_valid),
        .rx_ready        (rx_ready),
        .mem_address     (mem_address),
        .mem_data        (mem_data),
        .mem_write       (mem_write),
        .busy            (busy),
        .done            (done),
        .error           (error),
        .execution_enable(execution_enable),
        .words_written   (words_written)
    );

    typedef struct {
        logic [15:0] addr;
        logic [15:0] data;
    } wr_t;

    wr_t exp_q[$];
    int  checks = 0;
    int  passes = 0;
    int  cycle = 0;
    int  last_write_cycle = 0;
    int  writes_seen = 0;

    initial clock = 1'b0;
    always #5 clock = ~clock;
    always @(posedge clock) cycle++;

    task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual === expected) passes++;
        else $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, actual, expected, $time);
    endtask

    task automatic fail_now(input string name);
        checks++;
        $display("FAIL %s (t=%0t)", name, $time);
    endtask

    // Monitor: every write strobe must match the head of the expected queue.
    always @(negedge clock) begin
        if (reset_n && mem_write) begin
            wr_t e;
            writes_seen++;
            last_write_cycle = cycle;
            check("rx_ready_low_in_write", rx_ready, 0);
            if (exp_q.size() == 0) begin
                fail_now("unexpected_write");
            end else begin
                e = exp_q.pop_front();
                check("write_addr", mem_address, e.addr);
                check("write_data", mem_data, e.data);
            end
        end
    end

    task automatic pulse_start(input bit with_valid);
        @(negedge clock);
        start = 1'b1;
        if (with_valid) begin
            rx_valid = 1'b1;
            rx_data  = 8'h55;
        end
        @(negedge clock);
        start    = 1'b0;
        rx_valid = 1'b0;
    endtask

    // Drive one byte until it is accepted; optionally insert random gaps and
    // hold start high while presenting it.
    task automatic send_byte(input logic [7:0] b, input bit gappy, input bit with_start);
        int n;
        n = 0;
        forever begin
            @(negedge clock);
            start = with_start;
            if (gappy && $urandom_range(1, 0) == 0) begin
                rx_valid = 1'b0;
            end else begin
                rx_valid = 1'b1;
                rx_data  = b;
                if (rx_ready) break;
            end
            n++;
            if (n > 200) begin
                fail_now("byte_accept_timeout");
                break;
            end
        end
    endtask

    task automatic check_outputs_zero(input string tag);
        check({tag, "_rx_ready"}, rx_ready, 0);
        check({tag, "_mem_address"}, mem_address, 0);
        check({tag, "_mem_data"}, mem_data, 0);
        check({tag, "_mem_write"}, mem_write, 0);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_done"}, done, 0);
        check({tag, "_error"}, error, 0);
        check({tag, "_exec_en"}, execution_enable, 0);
        check({tag, "_words_written"}, words_written, 0);
    endtask

    // Reference model: length field decides outcome; each in-range word i
    // lands at BASE+i with data = {hi, lo}.
    task automatic run_load(input logic [7:0] s[$], input bit gappy, input int start_at,
                            input bit start_with_valid);
        int len, n_send, exp_ww, n;
        bit ok, exp_err;
        len     = {s[0], s[1]};
        ok      = (len != 0) && (len <= DEPTH);
        exp_err = (len > DEPTH);
        exp_ww  = ok ? len : 0;
        for (int i = 0; i < exp_ww; i++) begin
            wr_t w;
            w.addr = 16'(BASE + i);
            w.data = {s[2 + 2 * i], s[3 + 2 * i]};
            exp_q.push_back(w);
        end
        n_send      = 2 + 2 * exp_ww;
        writes_seen = 0;
        pulse_start(start_with_valid);
        for (int i = 0; i < n_send; i++) send_byte(s[i], gappy, i == start_at);
        @(negedge clock);
        rx_valid = 1'b0;
        start    = 1'b0;
        n = 0;
        while (busy && n < 50) begin
            @(negedge clock);
            n++;
        end
        check("load_finishes", busy, 0);
        if (ok) check("done_one_cycle_after_last_write", cycle - last_write_cycle, 1);
        check("write_count", writes_seen, exp_ww);
        check("pending_writes", exp_q.size(), 0);
        check("done", done, !exp_err);
        check("error", error, exp_err);
        check("execution_enable", execution_enable, !exp_err);
        check("words_written", words_written, exp_ww);
        check("rx_ready_idle", rx_ready, 0);
        exp_q.delete();
    endtask

    initial begin
        logic [7:0] s[$];
        int len;

        reset_n  = 1'b0;
        start    = 1'b0;
        rx_valid = 1'b0;
        rx_data  = 8'h00;
        repeat (3) @(negedge clock);
        check_outputs_zero("reset");
        reset_n = 1'b1;
        @(negedge clock);
        check_outputs_zero("after_reset");

        // Basic three-word image, rx_valid held high.
        s = '{8'h00, 8'h03, 8'h12, 8'h34, 8'hAB, 8'hCD, 8'h00, 8'hFF};
        run_load(s, 1'b0, -1, 1'b0);

        // Empty image.
        s = '{8'h00, 8'h00};
        run_load(s, 1'b0, -1, 1'b0);

        // Oversized length, then recovery; second start coincides with a byte.
        s = '{8'h00, 8'h41};
        run_load(s, 1'b0, -1, 1'b0);
        s = '{8'h00, 8'h01, 8'hBE, 8'hEF};
        run_load(s, 1'b0, -1, 1'b1);

        // Four-word image gap-free, then the same image with random gaps.
        s = '{8'h00, 8'h04, 8'hDE, 8'hAD, 8'hBE, 8'hEF, 8'h01, 8'h02, 8'hF0, 8'h0F};
        run_load(s, 1'b0, -1, 1'b0);
        run_load(s, 1'b1, -1, 1'b0);

        // Reset between DATA_HI and DATA_LO of word 2.
        exp_q.push_back('{16'(BASE), 16'h1122});
        exp_q.push_back('{16'(BASE + 1), 16'h3344});
        pulse_start(1'b0);
        s = '{8'h00, 8'h02, 8'h11, 8'h22, 8'h33};
        for (int i = 0; i < 5; i++) send_byte(s[i], 1'b0, 1'b0);
        @(negedge clock);
        rx_valid = 1'b0;
        reset_n  = 1'b0;
        #1;
        check_outputs_zero("mid_load_reset");
        check("state_idle_after_reset", dut.state, IDLE);
        check("second_word_not_written", exp_q.size(), 1);
        exp_q.delete();
        @(negedge clock);
        reset_n = 1'b1;
        s = '{8'h00, 8'h02, 8'hCA, 8'hFE, 8'h5A, 8'hA5};
        run_load(s, 1'b0, -1, 1'b0);

        // start held during the DATA_LO byte of word 1 must be ignored.
        s = '{8'h00, 8'h02, 8'h77, 8'h88, 8'h99, 8'hAA};
        run_load(s, 1'b0, 3, 1'b0);

        // Randomized images, some oversized.
        for (int t = 0; t < 8; t++) begin
            if ($urandom_range(3, 0) == 0) len = $urandom_range(300, DEPTH + 1);
            else                           len = $urandom_range(8, 1);
            s.delete();
            s.push_back(8'(len >> 8));
            s.push_back(8'(len));
            if (len <= DEPTH) begin
                for (int i = 0; i < 2 * len; i++) s.push_back(8'($urandom));
            end
            run_load(s, $urandom_range(1, 0) == 1, -1, $urandom_range(1, 0) == 1);
        end

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule

// File: doc/program_loader.md
Name: program_loader

Overview:
- Writer side of program RAM. Receives a byte stream over a valid/ready handshake and assembles 16-bit words.
- Writes the words into program RAM through the memory controller's input_address/input_data/rw path.
- Gates the execution driver enable so the core runs only after a complete, valid image is loaded.
- It is the loading counterpart to the PC-driven fetch path that reads program RAM.

Parameters:
ADDRESS_WIDTH, 16, width of the program RAM address bus
DATA_WIDTH, 16, program word width; fixed two bytes per word, high byte first
MEMORY_DEPTH, 64, maximum number of words accepted in one load
BASE_ADDRESS, 0, first program RAM address written

Ports:
clock  input  1  system clock, rising edge
reset_n  input  1  asynchronous active-low reset
start  input  1  single-cycle pulse; begins a load (accepted in IDLE, DONE, ERROR)
rx_data  input  8  incoming byte
rx_valid  input  1  rx_data valid
rx_ready  output  1  loader can accept a byte this cycle
mem_address  output  ADDRESS_WIDTH  write address to memory controller input_address
mem_data  output  DATA_WIDTH  write data to memory controller input_data
mem_write  output  1  write strobe, 1 = write, drives rw path
busy  output  1  load in progress (any state other than IDLE/DONE/ERROR)
done  output  1  image loaded successfully
error  output  1  length field exceeded MEMORY_DEPTH
execution_enable  output  1  drives execution driver enable; equals done
words_written  output  ADDRESS_WIDTH  count of words written in current/last load

Behaviour:
- Reset (async, reset_n=0): state IDLE; every output 0; internal count, address and data registers 0. Reset mid-load abandons the load immediately. mem_write falls asynchronously. Words already written remain in RAM.
- Byte transfer occurs on a rising edge with rx_valid=1 and rx_ready=1. rx_ready is registered and depends only on state: 1 in LEN_HI, LEN_LO, DATA_HI, DATA_LO; 0 otherwise.
- States: IDLE, LEN_HI, LEN_LO, DATA_HI, DATA_LO, WRITE, DONE, ERROR.
- IDLE/DONE/ERROR + start -> LEN_HI. Entering LEN_HI clears done, error, execution_enable and words_written. start is ignored in every other state.
- LEN_HI + transfer -> LEN_LO; the byte becomes length[15:8].
- LEN_LO + transfer: length = {hi, byte}.
  - length == 0 -> DONE.
  - length > MEMORY_DEPTH -> ERROR.
  - otherwise -> DATA_HI, with address = BASE_ADDRESS and remaining = length.
- DATA_HI + transfer -> DATA_LO; word[15:8] = byte.
- DATA_LO + transfer -> WRITE; word[7:0] = byte.
- WRITE lasts exactly one cycle:
  - mem_write=1, with mem_address/mem_data stable for the whole cycle.
  - On exit: address+1, remaining-1, words_written+1.
  - If remaining reaches 0 -> DONE, else -> DATA_HI.
- Address does not wrap: the length check guarantees last address = BASE_ADDRESS+length-1.
- Minimum throughput is 3 cycles per word (two byte transfers + WRITE). rx_valid gaps simply stall in the current state.
- DONE: done=1, execution_enable=1, held until next start or reset.
- ERROR: error=1, execution_enable=0, held until next start or reset. No memory writes occur for an errored load.
- mem_address and mem_data hold their last values outside WRITE. mem_write=0 outside WRITE.
- start coincident with rx_valid in IDLE: start wins; the byte is not consumed (rx_ready=0 that cycle).

Decomposition:
- Shared package program_loader_pkg holds:
  - the loader_state_t enum (eight states above);
  - BYTES_PER_WORD = 2;
  - LENGTH_FIELD_BYTES = 2.
- No sub-module is natural; single module of roughly 150-200 lines.

Test Plan:
- start, then stream 00 03 12 34 AB CD 00 FF with rx_valid held high. Required:
  - three mem_write pulses: addr 0 data 1234, addr 1 data ABCD, addr 2 data 00FF;
  - done=1 and execution_enable=1 on the cycle after the third WRITE;
  - words_written=3.
- start, stream 00 00. Required: DONE with no mem_write; done=1; words_written=0.
- start, stream 00 41 (65 > 64). Required: error=1, execution_enable=0, no mem_write, rx_ready=0. A second start followed by 00 01 BE EF writes BEEF at addr 0 and sets done.
- rx_valid toggled randomly (about 50%) during a 4-word load. Required: identical writes to the gap-free case; no byte lost or duplicated; mem_write never asserts while rx_ready=1.
- Assert reset_n=0 between DATA_HI and DATA_LO of word 2. Required:
  - all outputs 0 immediately (before the next clock edge);
  - state IDLE;
  - a subsequent start and full 2-word load completes normally from BASE_ADDRESS.
- start pulsed during DATA_LO. Required: pulse ignored; load completes and done sets as normal.
